// File: rtl/cnn_pkg.sv
// Shared CNN definitions: result element width, streamer FSM encoding and
// the flattened-map addressing helper used by the kernel's consumers.
package cnn_pkg;

   localparam int SUBKERNEL_OUT_BIT     = 21;
   localparam int CHANNEL_EXTENSION_BIT = 5;
   localparam int DEFAULT_DATA_BIT      = SUBKERNEL_OUT_BIT + CHANNEL_EXTENSION_BIT;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Bit offset of element (x,y) inside a row-major flattened map.
   function automatic int elem_offset(input int x, input int y,
                                      input int data_bit, input int width);
      return data_bit * (y * width + x);
   endfunction

endpackage

// File: rtl/conv_result_streamer_raster_counter.sv
// Raster-order x/y counter with clear and advance; flags the final element.
// Wraps back to (0,0) after the last element so coordinates stay in range.
module raster_counter
   import cnn_pkg::*;
#(
   parameter int WIDTH     = 27,
   parameter int HEIGHT    = 27,
   parameter int COORD_BIT = 6
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 advance,
   output logic [COORD_BIT-1:0] x,
   output logic [COORD_BIT-1:0] y,
   output logic                 last
);

   localparam logic [COORD_BIT-1:0] X_MAX = COORD_BIT'(WIDTH - 1);
   localparam logic [COORD_BIT-1:0] Y_MAX = COORD_BIT'(HEIGHT - 1);

   logic [COORD_BIT-1:0] x_q, x_d;
   logic [COORD_BIT-1:0] y_q, y_d;

   always_comb begin
      // NOTE: defaults first so every path assigns x_d/y_d and no latch is inferred.
      x_d = x_q;
      y_d = y_q;
      if (clear) begin
         x_d = '0;
         y_d = '0;
      end else if (advance) begin
         if (x_q == X_MAX) begin
            x_d = '0;
            y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/conv_result_streamer.sv
// Snapshots the kernel's flattened result map on the rise of conv_done and
// streams it in raster order over valid/ready. Option: CONV_STREAM_RELU_EN.
module conv_result_streamer
   import cnn_pkg::*;
#(
   parameter int DATA_BIT      = DEFAULT_DATA_BIT,
   parameter int OUTPUT_WIDTH  = 27,
   parameter int OUTPUT_HEIGHT = 27,
   parameter int COORD_BIT     = 6
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic [DATA_BIT*OUTPUT_WIDTH*OUTPUT_HEIGHT-1:0] conv_result,
   input  logic                                          conv_done,
   output logic [DATA_BIT-1:0]                           out_data,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic                                          out_last,
   output logic [COORD_BIT-1:0]                          out_x,
   output logic [COORD_BIT-1:0]                          out_y,
   output logic                                          busy,
   output logic                                          stream_done,
   output logic                                          overrun
);

   localparam int MAP_BIT = DATA_BIT * OUTPUT_WIDTH * OUTPUT_HEIGHT;

   logic [1:0]         state_q, state_d;
   logic               done_dly_q;
   logic               pending_q, pending_d;
   logic               overrun_q, overrun_d;
   logic [MAP_BIT-1:0] snapshot_q, snapshot_d;

   logic                 rise;
   logic                 cnt_clear, cnt_advance;
   logic [COORD_BIT-1:0] cnt_x, cnt_y;
   logic                 cnt_last;
   logic [DATA_BIT-1:0]  elem;

   assign rise = conv_done & ~done_dly_q;

   raster_counter #(
      .WIDTH     (OUTPUT_WIDTH),
      .HEIGHT    (OUTPUT_HEIGHT),
      .COORD_BIT (COORD_BIT)
   ) u_raster (
      .clock   (clock),
      .reset   (reset),
      .clear   (cnt_clear),
      .advance (cnt_advance),
      .x       (cnt_x),
      .y       (cnt_y),
      .last    (cnt_last)
   );

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      overrun_d   = overrun_q;
      snapshot_d  = snapshot_q;
      cnt_clear   = 1'b0;
      cnt_advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise || pending_q) begin
               snapshot_d = conv_result;
               cnt_clear  = 1'b1;
               pending_d  = 1'b0;
               state_d    = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (rise) overrun_d = 1'b1;
            if (out_ready) begin
               cnt_advance = 1'b1;
               if (cnt_last) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // A rise here is remembered and served from IDLE next cycle.
            if (rise) pending_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the snapshot is an ordinary register bank, so it takes the async reset like all other state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         done_dly_q <= 1'b0;
         pending_q  <= 1'b0;
         overrun_q  <= 1'b0;
         snapshot_q <= '0;
      end else begin
         state_q    <= state_d;
         done_dly_q <= conv_done;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         snapshot_q <= snapshot_d;
      end
   end

   always_comb begin
      elem = snapshot_q[elem_offset(int'(cnt_x), int'(cnt_y), DATA_BIT, OUTPUT_WIDTH) +: DATA_BIT];
   end

   assign out_valid   = (state_q == ST_STREAM);
   assign busy        = out_valid;
   assign stream_done = (state_q == ST_DONE);
   assign overrun     = overrun_q;
   assign out_x       = cnt_x;
   assign out_y       = cnt_y;
   assign out_last    = out_valid & cnt_last;

`ifdef CONV_STREAM_RELU_EN
   assign out_data = (out_valid && !elem[DATA_BIT-1]) ? elem : '0;
`else
   assign out_data = out_valid ? elem : '0;
`endif

endmodule

// File: tb/tb_conv_result_streamer.sv
// Randomised self-checking bench for conv_result_streamer on a 3x3 map of
// 8-bit elements, compared against a raster-order reference list.
module tb_conv_result_streamer;

   localparam int W  = 3;
   localparam int H  = 3;
   localparam int DB = 8;
   localparam int CB = 2;
   localparam int N  = W * H;

   logic            clock = 1'b0;
   logic            reset;
   logic [DB*N-1:0] conv_result;
   logic            conv_done;
   logic [DB-1:0]   out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;
   logic [CB-1:0]   out_x;
   logic [CB-1:0]   out_y;
   logic            busy;
   logic            stream_done;
   logic            overrun;

   int        n_cmp = 0;
   int        n_bad = 0;
   logic [7:0] cur_map [N];
   bit        ovr_exp = 1'b0;

   conv_result_streamer #(
      .DATA_BIT      (DB),
      .OUTPUT_WIDTH  (W),
      .OUTPUT_HEIGHT (H),
      .COORD_BIT     (CB)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .conv_result (conv_result),
      .conv_done   (conv_done),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .out_x       (out_x),
      .out_y       (out_y),
      .busy        (busy),
      .stream_done (stream_done),
      .overrun     (overrun)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected output value of one map element.
   function automatic logic [7:0] model(input logic [7:0] v);
`ifdef CONV_STREAM_RELU_EN
      return ($signed(v) < 0) ? 8'd0 : v;
`else
      return v;
`endif
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load_map();
      for (int i = 0; i < N; i++) conv_result[i*DB +: DB] = cur_map[i];
   endtask

   task automatic random_map();
      for (int i = 0; i < N; i++) cur_map[i] = 8'($urandom);
   endtask

   // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
   task automatic run_stream(input int ready_mode, input bit corrupt, input bit probe_ovr,
                             input bit pend_next, input bit pre_armed);
      int k   = 0;
      int cyc = 0;
      bit r;
      if (!pre_armed) begin
         load_map();
         conv_done = 1'b1;
      end
      step();
      check("valid_latency", out_valid, 1);
      check("busy_start", busy, 1);
      if (corrupt) conv_result = {N{8'h55}};
      while (k < N && cyc < 100) begin
         if (probe_ovr && cyc == 2) conv_done = 1'b0;
         if (probe_ovr && cyc == 3) begin
            conv_done = 1'b1;
            ovr_exp   = 1'b1;
         end
         if (pend_next && cyc == 1) conv_done = 1'b0;
         check("valid", out_valid, 1);
         check("data", out_data, model(cur_map[k]));
         check("x", out_x, k % W);
         check("y", out_y, k / W);
         check("last", out_last, (k == N - 1));
         check("stream_done_mid", stream_done, 0);
         case (ready_mode)
            0:       r = 1'b1;
            1:       r = (cyc % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         out_ready = r;
         step();
         if (r) k++;
         cyc++;
      end
      if (k < N) check("stream_timeout", k, N);
      out_ready = 1'b0;
      check("stream_done_pulse", stream_done, 1);
      check("valid_after", out_valid, 0);
      check("busy_after", busy, 0);
      check("overrun", overrun, ovr_exp);
      if (pend_next) begin
         conv_done = 1'b1;
         step();
         check("pend_idle_valid", out_valid, 0);
         check("pend_idle_done", stream_done, 0);
      end else begin
         step();
         check("stream_done_clear", stream_done, 0);
         if (conv_done) begin
            for (int i = 0; i < 3; i++) begin
               step();
               check("no_retrigger", out_valid, 0);
            end
         end
         conv_done = 1'b0;
         step();
      end
   endtask

   task automatic reset_mid();
      random_map();
      load_map();
      conv_done = 1'b1;
      out_ready = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         check("pre_reset_data", out_data, model(cur_map[i]));
         step();
      end
      #3;
      reset     = 1'b1;
      conv_done = 1'b0;
      ovr_exp   = 1'b0;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_x", out_x, 0);
      check("rst_y", out_y, 0);
      check("rst_done", stream_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_data", out_data, 0);
      #2;
      reset     = 1'b0;
      out_ready = 1'b0;
      step();
      check("post_rst_done", stream_done, 0);
      check("post_rst_valid", out_valid, 0);
   endtask

   initial begin
      reset       = 1'b1;
      conv_done   = 1'b0;
      out_ready   = 1'b0;
      conv_result = '0;
      #7;
      check("reset_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_last", out_last, 0);
      check("reset_done", stream_done, 0);
      check("reset_overrun", overrun, 0);
      check("reset_data", out_data, 0);
      check("reset_x", out_x, 0);
      check("reset_y", out_y, 0);
      #5;
      reset = 1'b0;
      step();

      for (int i = 0; i < N; i++) cur_map[i] = 8'(i + 1);
      run_stream(0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_stream(1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_stream(0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_stream(0, 1'b0, 1'b1, 1'b0, 1'b0);

      random_map();
      run_stream(2, 1'b0, 1'b0, 1'b1, 1'b0);
      run_stream(2, 1'b0, 1'b0, 1'b0, 1'b1);

      cur_map = '{8'hFD, 8'h05, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h02, 8'hFE, 8'h09};
      run_stream(0, 1'b0, 1'b0, 1'b0, 1'b0);

      reset_mid();
      for (int i = 0; i < N; i++) cur_map[i] = 8'(i + 1);
      run_stream(0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         random_map();
         run_stream(2, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
